control_unit_mc_fsm: RTL
========================

Name: control_unit_mc_fsm

Overview:
- Next-generation multi-cycle control FSM for the SigmaCore datapath.
- Extends the RV32I subset to LOAD, STORE, OP, OP-IMM, LUI, AUIPC, BRANCH, JAL and JALR.
- Handles variable-latency memory through a mem_ready handshake, with a parametrised watchdog and a retired-instruction counter.
- Sits between the IR opcode field and the datapath muxes and enables. Encodings come from sigma_pkg.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive not-ready memory cycles before fault. 0 disables the watchdog.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- branch_cond  in  1  comparator result for the current branch (funct3 already applied)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, old_pc_write, ir_write, mdr_write, reg_write, mem_read, mem_write, reg_a_write, reg_b_write, alu_out_write  out  1 each  strobes
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 ALU result with bit0 cleared
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (PC+4)
- alu_src_a  out  2  00 RegA, 01 PC, 10 OldPC, 11 zero
- alu_src_b  out  2  00 RegB, 01 immediate, 10 constant 4
- imm_src  out  3  IMM_TYPE_* from sigma_pkg
- alu_op_type  out  2  ALU_OP_TYPE_LSU (add), _R_I, _BRANCH
- instret  out  CNT_W  retired instruction count
- mem_timeout  out  1  sticky fault flag
- state_o  out  4  current state, for debug

Behaviour:
- Reset:
  - State goes to FETCH; wait_cnt, instret and mem_timeout clear to 0.
  - While reset is high, all strobes are forced to 0 and mux outputs take their default values.
- Default values when not listed below: all strobes 0, muxes 00, IMM_TYPE_NONE, ALU_OP_TYPE_R_I.
- Output type: Moore, except strobes qualified by mem_ready or branch_cond, which are Mealy.

State behaviour:
- FETCH:
  - Drives mem_read=1, a=PC, b=4, LSU.
  - When mem_ready=1: ir_write, pc_write (source 00) and old_pc_write assert; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives reg_a_write, reg_b_write, alu_out_write, a=OldPC, b=imm, imm B, LSU. This precomputes the branch target.
  - Next state by opcode:
    - LOAD or STORE → MEM_ADDR
    - OP → EXEC_R
    - OP-IMM → EXEC_I
    - LUI or AUIPC → EXEC_U
    - BRANCH → BRANCH
    - JAL → JAL
    - JALR → JALR
    - any other opcode → FETCH (see Optional Feature)
- MEM_ADDR:
  - Drives a=RegA, b=imm, imm I for LOAD or S for STORE, LSU, alu_out_write.
  - Goes to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD:
  - Holds mem_read=1 until mem_ready.
  - On mem_ready, pulses mdr_write and goes to WB_LOAD.
- WB_LOAD: reg_write, mem_to_reg=01; go to FETCH.
- MEM_WR: holds mem_write=1 until mem_ready, then goes to FETCH.
- EXEC_R: a=RegA, b=RegB, R_I, alu_out_write; go to WB_ALU.
- EXEC_I: a=RegA, b=imm I, R_I, alu_out_write; go to WB_ALU.
- EXEC_U: a=zero (LUI) or OldPC (AUIPC), b=imm U, LSU, alu_out_write; go to WB_ALU.
- WB_ALU: reg_write, mem_to_reg=00; go to FETCH.
- BRANCH:
  - Drives a=RegA, b=RegB, ALU_OP_TYPE_BRANCH, pc_source=01.
  - pc_write = branch_cond.
  - Go to FETCH.
- JAL:
  - Drives a=OldPC, b=imm J, LSU, pc_source=00, pc_write.
  - Also drives reg_write with mem_to_reg=10. The register file samples the pre-edge PC, which holds PC+4.
  - Go to FETCH.
- JALR: same as JAL, but a=RegA, imm I, pc_source=10.
- FAULT: all strobes 0; the FSM stays in FAULT until reset.

Retired-instruction counter:
- instret increments by 1 on every clock edge where next_state=FETCH, current state is not FETCH, and the FSM is not entering FAULT.
- It wraps modulo 2^CNT_W.

Watchdog:
- wait_cnt increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
- It clears on mem_ready or on any state change.
- When wait_cnt=TIMEOUT_CYCLES-1 and mem_ready=0, the next state is FAULT and mem_timeout is set.
- If mem_ready arrives in that same cycle, mem_ready wins.

Optional Feature:
- Macro: SIGMA_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to state TRAP. This is the final, non-retiring state; instret does not increment.
  - Adds output illegal_instr, which is 1 in TRAP only.
  - The FSM stays in TRAP until reset.
- Undefined:
  - An unknown opcode returns to FETCH and is not counted.
  - The illegal_instr port and the TRAP state do not exist.

Test Plan:
- ADDI, mem_ready tied to 1 → FETCH, DECODE, EXEC_I, WB_ALU, FETCH in 4 cycles; reg_write high in WB_ALU only; instret 0 → 1.
- LOAD with mem_ready low for 3 cycles in MEM_RD → mem_read held 4 cycles; mdr_write is a single pulse in the ready cycle; WB_LOAD asserts mem_to_reg=01.
- BRANCH with branch_cond=0, then a second BRANCH with branch_cond=1 → pc_write is 0, then 1 with pc_source=01; each branch retires in 3 cycles.
- JAL → a single JAL cycle with pc_write=1, reg_write=1, mem_to_reg=10, imm J.
- Defaults TIMEOUT_CYCLES=16, mem_ready stuck low in FETCH → FAULT entered after 16 cycles with mem_timeout=1 and held. A reset pulse mid-FETCH clears state to FETCH and instret to 0.
- Opcode 0x7F → FETCH without SIGMA_ILLEGAL_TRAP_EN; TRAP with illegal_instr=1 when the macro is defined.

Source files
------------

// File: rtl/control_unit_mc_fsm.sv
// Multi-cycle control FSM for the SigmaCore datapath; encodings mirror sigma_pkg.
// Optional illegal-opcode trap state and illegal_instr port: define SIGMA_ILLEGAL_TRAP_EN.
module control_unit_mc_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             old_pc_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_a_write,
  output logic             reg_b_write,
  output logic             alu_out_write,
  output logic [1:0]       pc_source,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [1:0]       alu_op_type,
  output logic [CNT_W-1:0] instret,
  output logic             mem_timeout,
`ifdef SIGMA_ILLEGAL_TRAP_EN
  output logic             illegal_instr,
`endif
  output logic [3:0]       state_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [2:0] IMM_TYPE_I    = 3'd1;
  localparam logic [2:0] IMM_TYPE_S    = 3'd2;
  localparam logic [2:0] IMM_TYPE_B    = 3'd3;
  localparam logic [2:0] IMM_TYPE_U    = 3'd4;
  localparam logic [2:0] IMM_TYPE_J    = 3'd5;

  localparam logic [1:0] ALU_OP_TYPE_LSU    = 2'd0;
  localparam logic [1:0] ALU_OP_TYPE_R_I    = 2'd1;
  localparam logic [1:0] ALU_OP_TYPE_BRANCH = 2'd2;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_WB_LOAD  = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_EXEC_U   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_FAULT    = 4'd13;
`ifdef SIGMA_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd14;
`endif

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              memTimeout_q, memTimeout_d;
  logic              waitState, watchdogExpired, retire;

  assign waitState       = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign watchdogExpired = (TIMEOUT_CYCLES != 0) && waitState && !mem_ready &&
                           (waitCnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE; else if (watchdogExpired) state_d = S_FAULT;
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_LUI, OPC_AUIPC:  state_d = S_EXEC_U;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
`ifdef SIGMA_ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_LOAD; else if (watchdogExpired) state_d = S_FAULT;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH; else if (watchdogExpired) state_d = S_FAULT;
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_d = S_WB_ALU;
      S_WB_LOAD, S_WB_ALU, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
`ifdef SIGMA_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // A DECODE->FETCH return only happens for an unknown opcode, which never retires.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);

  always_comb begin
    waitCnt_d = '0;
    if (waitState && !mem_ready && (state_d == state_q))
      waitCnt_d = waitCnt_q + WAIT_W'(1);
    instret_d    = retire ? instret_q + CNT_W'(1) : instret_q;
    memTimeout_d = memTimeout_q | ((state_d == S_FAULT) && (state_q != S_FAULT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      waitCnt_q    <= '0;
      instret_q    <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      instret_q    <= instret_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  // Control outputs; the mem_ready/branch_cond qualified strobes are the only Mealy terms.
  always_comb begin
    pc_write      = 1'b0;
    old_pc_write  = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_a_write   = 1'b0;
    reg_b_write   = 1'b0;
    alu_out_write = 1'b0;
    pc_source     = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = IMM_TYPE_NONE;
    alu_op_type   = ALU_OP_TYPE_R_I;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read     = 1'b1;
          alu_src_a    = 2'b01;
          alu_src_b    = 2'b10;
          alu_op_type  = ALU_OP_TYPE_LSU;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
          old_pc_write = mem_ready;
        end
        S_DECODE: begin
          reg_a_write   = 1'b1;
          reg_b_write   = 1'b1;
          alu_out_write = 1'b1;
          alu_src_a     = 2'b10;
          alu_src_b     = 2'b01;
          imm_src       = IMM_TYPE_B;
          alu_op_type   = ALU_OP_TYPE_LSU;
        end
        S_MEM_ADDR: begin
          alu_out_write = 1'b1;
          alu_src_b     = 2'b01;
          imm_src       = (opcode == OPC_STORE) ? IMM_TYPE_S : IMM_TYPE_I;
          alu_op_type   = ALU_OP_TYPE_LSU;
        end
        S_MEM_RD: begin
          mem_read  = 1'b1;
          mdr_write = mem_ready;
        end
        S_WB_LOAD: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WR: mem_write = 1'b1;
        S_EXEC_R: alu_out_write = 1'b1;
        S_EXEC_I: begin
          alu_out_write = 1'b1;
          alu_src_b     = 2'b01;
          imm_src       = IMM_TYPE_I;
        end
        S_EXEC_U: begin
          alu_out_write = 1'b1;
          alu_src_a     = (opcode == OPC_LUI) ? 2'b11 : 2'b10;
          alu_src_b     = 2'b01;
          imm_src       = IMM_TYPE_U;
          alu_op_type   = ALU_OP_TYPE_LSU;
        end
        S_WB_ALU: reg_write = 1'b1;
        S_BRANCH: begin
          pc_source   = 2'b01;
          alu_op_type = ALU_OP_TYPE_BRANCH;
          pc_write    = branch_cond;
        end
        S_JAL, S_JALR: begin
          pc_write    = 1'b1;
          reg_write   = 1'b1;
          mem_to_reg  = 2'b10;
          alu_src_b   = 2'b01;
          alu_op_type = ALU_OP_TYPE_LSU;
          if (state_q == S_JAL) begin
            alu_src_a = 2'b10;
            imm_src   = IMM_TYPE_J;
          end else begin
            pc_source = 2'b10;
            imm_src   = IMM_TYPE_I;
          end
        end
        default: ;
      endcase
    end
  end

  assign instret     = instret_q;
  assign mem_timeout = memTimeout_q;
  assign state_o     = state_q;
`ifdef SIGMA_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule
